// File: rtl/sdio_pkg.sv
// Shared SD CMD-line definitions: field widths, CRC7 polynomial, receiver states
// and the serial CRC7 step.
package sdio_pkg;

    localparam int unsigned FRAME_LEN = 48;
    localparam int unsigned CMD_W     = 6;
    localparam int unsigned ARG_W     = 32;
    localparam int unsigned CRC_W     = 7;
    localparam int unsigned BODY_W    = CMD_W + ARG_W;
    localparam int unsigned CNT_W     = 6;

    localparam logic [CRC_W-1:0] CRC7_POLY = 7'h09;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TXBIT = 3'd1,
        ST_BODY  = 3'd2,
        ST_CRC   = 3'd3,
        ST_ENDB  = 3'd4
    } rx_state_e;

    typedef struct packed {
        logic [CMD_W-1:0] cmd;
        logic [ARG_W-1:0] arg;
        logic             crc_err;
        logic             frame_err;
    } rx_frame_t;

    // One serial CRC7 step, MSB-first.
    function automatic logic [CRC_W-1:0] crc7_step(input logic [CRC_W-1:0] crc,
                                                    input logic             b);
        logic fb;
        fb = crc[CRC_W-1] ^ b;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : CRC_W'(0));
    endfunction

endpackage

// File: rtl/sdcrc7.sv
// Serial CRC7 accumulator; clear and enable together restart the CRC with the
// current bit as the first bit.
module sdcrc7
    import sdio_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic             i_bit,
    output logic [CRC_W-1:0] o_crc
);

    logic [CRC_W-1:0] crc_q, crc_d;

    always_comb begin
        crc_d = i_clear ? CRC_W'(0) : crc_q;
        if (i_enable) begin
            crc_d = crc7_step(crc_d, i_bit);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign o_crc = crc_q;

endmodule

// File: rtl/sdcmd_rxframe.sv
// Card-side CMD-line receiver: assembles 48-bit host commands from strobed line
// samples, checks CRC7/end bit and presents them through a one-deep valid/ready register.
module sdcmd_rxframe
    import sdio_pkg::*;
#(
    parameter int unsigned LGTIMEOUT    = 10,
    parameter bit          OPT_DROP_BAD = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_ckstb,
    input  logic             i_cmd,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [CMD_W-1:0] o_cmd,
    output logic [ARG_W-1:0] o_arg,
    output logic             o_crc_err,
    output logic             o_frame_err,
    output logic             o_overrun,
    output logic             o_timeout,
    output logic             o_busy
);

    rx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BODY_W-1:0]      body_q, body_d;
    logic [CRC_W-1:0]       rxcrc_q, rxcrc_d;
    logic [LGTIMEOUT-1:0]   wd_q, wd_d;
    logic [CRC_W-1:0]       crc_calc;

    rx_frame_t              frame_q, frame_d;
    logic                   valid_q, valid_d;
    logic                   overrun_q, overrun_d;
    logic                   timeout_q, timeout_d;
    logic                   busy_q, busy_d;

    logic                   crc_clr_c, crc_en_c;
    logic                   wd_expire_c, complete_c;
    logic                   crc_ok_c, bad_c, handshake_c;

    sdcrc7 u_crc (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (crc_clr_c),
        .i_enable (crc_en_c),
        .i_bit    (i_cmd),
        .o_crc    (crc_calc)
    );

    // Frame-walking FSM; the watchdog and enable win over strobe sampling.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        body_d      = body_q;
        rxcrc_d     = rxcrc_q;
        crc_clr_c   = 1'b0;
        crc_en_c    = 1'b0;
        complete_c  = 1'b0;
        wd_expire_c = (state_q != ST_IDLE) && (wd_q == '1);

        if (wd_expire_c || !i_enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (i_ckstb) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!i_cmd) begin
                        state_d   = ST_TXBIT;
                        cnt_d     = '0;
                        crc_clr_c = 1'b1;
                        crc_en_c  = 1'b1;
                    end
                end
                ST_TXBIT: begin
                    crc_en_c = 1'b1;
                    cnt_d    = '0;
                    state_d  = i_cmd ? ST_BODY : ST_IDLE;
                end
                ST_BODY: begin
                    crc_en_c = 1'b1;
                    body_d   = {body_q[BODY_W-2:0], i_cmd};
                    if (cnt_q == CNT_W'(BODY_W - 1)) begin
                        state_d = ST_CRC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_CRC: begin
                    rxcrc_d = {rxcrc_q[CRC_W-2:0], i_cmd};
                    if (cnt_q == CNT_W'(CRC_W - 1)) begin
                        state_d = ST_ENDB;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_ENDB: begin
                    complete_c = 1'b1;
                    state_d    = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        if (state_q == ST_IDLE || i_ckstb || wd_expire_c) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + LGTIMEOUT'(1);
        end
    end

    // Output register: hold until handshake, overrun drops a frame arriving on a stalled slot.
    always_comb begin
        crc_ok_c    = (rxcrc_q == crc_calc);
        bad_c       = !crc_ok_c || !i_cmd;
        handshake_c = valid_q && i_ready;

        valid_d   = valid_q;
        frame_d   = frame_q;
        overrun_d = overrun_q;
        timeout_d = wd_expire_c;
        busy_d    = (state_d != ST_IDLE);

        if (OPT_DROP_BAD) begin
            frame_d.crc_err   = 1'b0;
            frame_d.frame_err = 1'b0;
        end
        if (handshake_c) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
        if (complete_c) begin
            if (valid_q && !i_ready) begin
                overrun_d = 1'b1;
            end else if (OPT_DROP_BAD && bad_c) begin
                frame_d.crc_err   = !crc_ok_c;
                frame_d.frame_err = !i_cmd;
            end else begin
                valid_d           = 1'b1;
                frame_d.cmd       = body_q[BODY_W-1 -: CMD_W];
                frame_d.arg       = body_q[ARG_W-1:0];
                frame_d.crc_err   = !crc_ok_c;
                frame_d.frame_err = !i_cmd;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            body_q    <= '0;
            rxcrc_q   <= '0;
            wd_q      <= '0;
            frame_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            body_q    <= body_d;
            rxcrc_q   <= rxcrc_d;
            wd_q      <= wd_d;
            frame_q   <= frame_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_cmd       = frame_q.cmd;
    assign o_arg       = frame_q.arg;
    assign o_crc_err   = frame_q.crc_err;
    assign o_frame_err = frame_q.frame_err;
    assign o_overrun   = overrun_q;
    assign o_timeout   = timeout_q;
    assign o_busy      = busy_q;

endmodule
